sgd_model_writeback_engine: RTL and testbench

Parametrised model-snapshot writer for the SGD datapath. Reads the distributed model memory (ENGINE_NUM banks, one wide word per engine per row), slices each word into OUT_WIDTH beats, and streams them to the host-write interface as one command plus data burst per snapshot. Snapshots are taken every EPOCH_INTERVAL-th epoch trigger into consecutive host regions. Single clock domain; any CDC sits downstream.

---
 rtl/sgd_model_writeback_engine_if.sv | 48 ++++
 rtl/sgd_model_writeback_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_sgd_model_writeback_engine.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgd_model_writeback_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : sgd_model_writeback_engine_if
// Purpose  : Bundles the model-memory read port, host write command channel
//            and host write data channel of the model writeback engine.
// Revision : 1.0 - initial release
// ============================================================================
interface sgd_model_writeback_engine_if #(
  parameter int ENGINE_NUM    = 8,
  parameter int BANK_WIDTH    = 2048,
  parameter int OUT_WIDTH     = 512,
  parameter int ROW_ADDR_BITS = 8
);
  // Model memory read port
  logic                             mem_rd_en;
  logic [ROW_ADDR_BITS-1:0]         mem_rd_addr;
  logic [ENGINE_NUM*BANK_WIDTH-1:0] mem_rd_data;
  // Host write command channel
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [63:0]                      cmd_addr;
  logic [31:0]                      cmd_len;
  // Host write data channel
  logic [OUT_WIDTH-1:0]             data_out;
  logic                             data_valid;
  logic                             data_ready;

  // Engine side
  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready,
    output data_out, data_valid,
    input  data_ready
  );

  // Memory / host side
  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready,
    input  data_out, data_valid,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/sgd_model_writeback_engine.sv
`default_nettype none
// ============================================================================
// Module   : sgd_model_writeback_engine
// Purpose  : Every Nth epoch trigger, reads the banked model memory row by
//            row, slices each row into output beats and streams them to the
//            host as one write command plus data burst per snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module sgd_model_writeback_engine #(
  parameter int ENGINE_NUM    = 8,
  parameter int BANK_WIDTH    = 2048,
  parameter int OUT_WIDTH     = 512,
  parameter int ROW_ADDR_BITS = 8,
  parameter int RD_LATENCY    = 2,
  parameter int FIFO_DEPTH    = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   start,
  input  wire logic [63:0]            addr_base,
  input  wire logic [ROW_ADDR_BITS:0] num_rows,
  input  wire logic [15:0]            epoch_interval,
  input  wire logic [31:0]            num_snapshots,
  input  wire logic                   epoch_trigger,
  output logic                        busy,
  output logic                        done,
  output logic                        err_cfg,
  output logic                        err_trig_drop,
  output logic [31:0]                 beats_sent,
  sgd_model_writeback_engine_if.master bus
);

  localparam int          SLICES    = BANK_WIDTH / OUT_WIDTH;
  localparam int          BPR       = ENGINE_NUM * SLICES;
  localparam int          BEAT_W    = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          ROW_W     = ENGINE_NUM * BANK_WIDTH;
  localparam logic [31:0] C_BPR     = 32'(BPR);
  localparam logic [31:0] C_ROW_BYT = 32'(BPR * (OUT_WIDTH / 8));

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_CMD    = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]             state_q, state_d;
  // Latched configuration and snapshot bookkeeping
  logic [63:0]            addr_q;
  logic [31:0]            len_q;
  logic [31:0]            total_beats_q;
  logic [ROW_ADDR_BITS:0] rows_q;
  logic [15:0]            interval_q;
  logic [31:0]            nsnap_q;
  logic [31:0]            snap_idx_q;
  logic [15:0]            trig_cnt_q;
  logic                   done_q, err_cfg_q, err_drop_q;
  logic [31:0]            beats_sent_q;
  // Read side
  logic [ROW_ADDR_BITS:0] rd_rows_q;
  logic [RD_LATENCY-1:0]  rdv_q, rdv_d;
  logic [ROW_W-1:0]       rowbuf_q;
  logic                   rowbuf_full_q;
  logic [BEAT_W-1:0]      push_idx_q;
  logic [31:0]            out_cnt_q;
  // Output FIFO
  logic [OUT_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, rd_ptr_q;

  logic        cfg_bad, start_ok, arm_fire, more_snaps, last_acc;
  logic [16:0] trig_sum;
  logic        fifo_full, fifo_empty, push, last_push, pop, capture, rd_issue;
  logic [31:0] rows32;

  assign rows32     = 32'(num_rows);
  assign cfg_bad    = (num_rows == '0) || (num_snapshots == 32'd0);
  assign start_ok   = start && (state_q == S_IDLE) && !cfg_bad;
  assign trig_sum   = {1'b0, trig_cnt_q} + {16'd0, epoch_trigger};
  assign arm_fire   = trig_sum >= {1'b0, interval_q};
  assign more_snaps = ({1'b0, snap_idx_q} + 33'd1) < {1'b0, nsnap_q};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && bus.data_ready;
  assign push       = rowbuf_full_q && !fifo_full;
  assign last_push  = push && (push_idx_q == BEAT_W'(BPR - 1));
  assign capture    = rdv_q[RD_LATENCY-1];
  assign last_acc   = (state_q == S_STREAM) && pop && (out_cnt_q == total_beats_q - 32'd1);

  // The next row is requested once nothing is in flight and the row buffer
  // is free, or is draining its final beat this very cycle.
  assign rd_issue = (state_q == S_STREAM) && (rd_rows_q < rows_q) && (rdv_q == '0) &&
                    (!rowbuf_full_q || last_push);

  generate
    if (RD_LATENCY == 1) begin : g_lat_one
      assign rdv_d = rd_issue;
    end else begin : g_lat_multi
      assign rdv_d = {rdv_q[RD_LATENCY-2:0], rd_issue};
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_ARMED;
      S_ARMED:  if (arm_fire) state_d = S_CMD;
      S_CMD:    if (bus.cmd_ready) state_d = S_STREAM;
      default:  if (last_acc) state_d = more_snaps ? S_ARMED : S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy          = (state_q != S_IDLE);
    bus.cmd_valid = (state_q == S_CMD);
    bus.mem_rd_en = rd_issue;
  end

  // Configuration latch, trigger counting, snapshot advance and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q        <= '0;
      len_q         <= '0;
      total_beats_q <= '0;
      rows_q        <= '0;
      interval_q    <= '0;
      nsnap_q       <= '0;
      snap_idx_q    <= '0;
      trig_cnt_q    <= '0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_drop_q    <= 1'b0;
      beats_sent_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err_cfg_q <= 1'b1;
            end else begin
              addr_q        <= addr_base;
              len_q         <= rows32 * C_ROW_BYT;
              total_beats_q <= rows32 * C_BPR;
              rows_q        <= num_rows;
              interval_q    <= (epoch_interval == 16'd0) ? 16'd1 : epoch_interval;
              nsnap_q       <= num_snapshots;
              snap_idx_q    <= '0;
              trig_cnt_q    <= '0;
              beats_sent_q  <= '0;
            end
          end
        end
        S_ARMED: trig_cnt_q <= arm_fire ? 16'd0 : trig_sum[15:0];
        default: begin
          // A trigger coinciding with the return to ARMED counts toward the
          // next snapshot; any other trigger while writing is lost.
          if (epoch_trigger) begin
            if (last_acc && more_snaps) trig_cnt_q <= 16'd1;
            else                        err_drop_q <= 1'b1;
          end
          if (last_acc) begin
            if (more_snaps) begin
              snap_idx_q <= snap_idx_q + 32'd1;
              addr_q     <= addr_q + {32'd0, len_q};
            end else begin
              done_q <= 1'b1;
            end
          end
        end
      endcase
      if (pop && (beats_sent_q != 32'hFFFF_FFFF)) beats_sent_q <= beats_sent_q + 32'd1;
    end
  end

  // Row read sequencing, latency pipeline and row-buffer unload control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_rows_q     <= '0;
      rdv_q         <= '0;
      rowbuf_full_q <= 1'b0;
      push_idx_q    <= '0;
      out_cnt_q     <= '0;
    end else begin
      rdv_q <= rdv_d;
      if ((state_q == S_CMD) && bus.cmd_ready) begin
        rd_rows_q <= '0;
        out_cnt_q <= '0;
      end else begin
        if (rd_issue) rd_rows_q <= rd_rows_q + 1'b1;
        if (pop)      out_cnt_q <= out_cnt_q + 32'd1;
      end
      if (push) begin
        push_idx_q <= last_push ? '0 : push_idx_q + 1'b1;
        if (last_push) rowbuf_full_q <= 1'b0;
      end
      if (capture) begin
        rowbuf_full_q <= 1'b1;
        push_idx_q    <= '0;
      end
    end
  end

  // Row buffer data capture
  always_ff @(posedge clk) begin
    if (capture) rowbuf_q <= bus.mem_rd_data;
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= rowbuf_q[push_idx_q * OUT_WIDTH +: OUT_WIDTH];
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign bus.mem_rd_addr = rd_rows_q[ROW_ADDR_BITS-1:0];
  assign bus.cmd_addr    = addr_q;
  assign bus.cmd_len     = len_q;
  assign bus.data_valid  = !fifo_empty;
  assign bus.data_out    = fifo_empty ? '0 : fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign done            = done_q;
  assign err_cfg         = err_cfg_q;
  assign err_trig_drop   = err_drop_q;
  assign beats_sent      = beats_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_sgd_model_writeback_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgd_model_writeback_engine
// Purpose  : Scoreboard bench for the model writeback engine: directed
//            snapshots, stalls, trigger drop, bad config and mid-burst reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sgd_model_writeback_engine;
  localparam int EN  = 8;
  localparam int BW  = 2048;
  localparam int OW  = 512;
  localparam int RAB = 8;
  localparam int BPR = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [63:0] addr_base = '0;
  logic [RAB:0] num_rows = '0;
  logic [15:0] epoch_interval = '0;
  logic [31:0] num_snapshots = '0;
  logic epoch_trigger = 1'b0;
  logic busy, done, err_cfg, err_trig_drop;
  logic [31:0] beats_sent;

  sgd_model_writeback_engine_if #(.ENGINE_NUM(EN), .BANK_WIDTH(BW), .OUT_WIDTH(OW),
                                  .ROW_ADDR_BITS(RAB)) bus ();

  sgd_model_writeback_engine #(.ENGINE_NUM(EN), .BANK_WIDTH(BW), .OUT_WIDTH(OW),
                               .ROW_ADDR_BITS(RAB), .RD_LATENCY(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_base(addr_base), .num_rows(num_rows),
    .epoch_interval(epoch_interval), .num_snapshots(num_snapshots),
    .epoch_trigger(epoch_trigger), .busy(busy), .done(done), .err_cfg(err_cfg),
    .err_trig_drop(err_trig_drop), .beats_sent(beats_sent), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int dmode = 0;
  int cmode = 0;
  logic [63:0]   exp_addr[$];
  logic [31:0]   exp_len[$];
  logic [OW-1:0] exp_beat[$];

  // Memory word k (32 bits) = {5A, row, beat, chunk}, engine e at bits e*BW
  function automatic logic [EN*BW-1:0] row_word(input logic [7:0] r);
    logic [EN*BW-1:0] w;
    for (int k = 0; k < EN*BW/32; k++) w[k*32 +: 32] = {8'h5A, r, 8'(k / 16), 8'(k % 16)};
    return w;
  endfunction

  function automatic logic [OW-1:0] beat_word(input logic [7:0] r, input int b);
    logic [OW-1:0] v;
    for (int c = 0; c < OW/32; c++) v[c*32 +: 32] = {8'h5A, r, 8'(b), 8'(c)};
    return v;
  endfunction

  // Model memory with a two-cycle read latency
  logic [7:0] a1 = '0;
  logic [7:0] a2 = '0;
  always_ff @(posedge clk) begin
    a1 <= bus.mem_rd_addr;
    a2 <= a1;
  end
  always_comb bus.mem_rd_data = row_word(a2);

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Ready drivers
  initial begin
    int phase = 0;
    int ccnt = 0;
    bus.data_ready = 1'b1;
    bus.cmd_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      bus.data_ready = (dmode == 0) ? 1'b1 : ((phase % 4) == 0);
      if (cmode == 0) begin
        bus.cmd_ready = 1'b1;
      end else begin
        ccnt = bus.cmd_valid ? ccnt + 1 : 0;
        bus.cmd_ready = (ccnt >= 10);
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake
  initial begin
    logic          hold = 1'b0;
    logic [OW-1:0] hold_data = '0;
    logic [63:0]   ea;
    logic [31:0]   el;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (exp_addr.size() == 0) begin
            chk("cmd_unexpected", 1, 0);
          end else begin
            ea = exp_addr.pop_front();
            el = exp_len.pop_front();
            chk("cmd_addr", bus.cmd_addr, ea);
            chk("cmd_len", bus.cmd_len, el);
          end
        end
        if (hold) begin
          chk("stall_valid", bus.data_valid, 1);
          chk("stall_data", bus.data_out, hold_data);
        end
        hold      = bus.data_valid && !bus.data_ready;
        hold_data = bus.data_out;
        if (bus.data_valid && bus.data_ready) begin
          if (exp_beat.size() == 0) chk("beat_unexpected", 1, 0);
          else                      chk("beat", bus.data_out, exp_beat.pop_front());
        end
        if (done) done_cnt++;
        if (bus.mem_rd_en) rd_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic trig();
    epoch_trigger = 1'b1;
    tick(1);
    epoch_trigger = 1'b0;
  endtask

  task automatic cfg(input logic [63:0] b, input int rows, input int itv, input int ns);
    addr_base = b;
    num_rows = 9'(rows);
    epoch_interval = 16'(itv);
    num_snapshots = 32'(ns);
  endtask

  task automatic expect_snap(input logic [63:0] a, input int rows);
    exp_addr.push_back(a);
    exp_len.push_back(32'(rows * BPR * OW / 8));
    for (int r = 0; r < rows; r++)
      for (int b = 0; b < BPR; b++) exp_beat.push_back(beat_word(8'(r), b));
  endtask

  task automatic wait_beats_left(input int n, input int budget);
    int t = 0;
    while (exp_beat.size() > n && t < budget) begin tick(1); t++; end
    if (exp_beat.size() > n) chk("timeout_beats", 32'(exp_beat.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin tick(1); t++; end
    if (busy) chk("timeout_idle", busy, 0);
  endtask

  initial begin
    int d0;
    int r0;
    tick(5);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_beats_sent", beats_sent, 0);
    rst_n = 1'b1;
    tick(2);

    // Single snapshot, two rows
    cfg(64'h1000, 2, 1, 1);
    expect_snap(64'h1000, 2);
    d0 = done_cnt;
    pulse_start();
    chk("t1_busy", busy, 1);
    trig();
    wait_idle(1000);
    tick(1);
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);
    chk("t1_beats_sent", beats_sent, 64);
    chk("t1_leftover", 32'(exp_beat.size() + exp_addr.size()), 0);

    // Interval 3, two one-row snapshots
    cfg(64'h2000, 1, 3, 2);
    expect_snap(64'h2000, 1);
    expect_snap(64'h2800, 1);
    d0 = done_cnt;
    pulse_start();
    trig(); tick(2); trig(); tick(5);
    chk("t2_no_cmd_early", 32'(exp_addr.size()), 2);
    trig();
    wait_beats_left(32, 500);
    tick(2);
    chk("t2_armed", busy, 1);
    trig(); tick(2); trig(); tick(5);
    chk("t2_no_cmd2_early", 32'(exp_addr.size()), 1);
    trig();
    wait_idle(1000);
    tick(1);
    chk("t2_done_cnt", 32'(done_cnt - d0), 1);
    chk("t2_beats_sent", beats_sent, 64);
    chk("t2_no_drop", err_trig_drop, 0);
    chk("t2_leftover", 32'(exp_beat.size() + exp_addr.size()), 0);

    // Stalled output, delayed command accept, interval 0, address wrap
    dmode = 1;
    cmode = 1;
    cfg(64'hFFFF_FFFF_FFFF_F800, 2, 0, 2);
    expect_snap(64'hFFFF_FFFF_FFFF_F800, 2);
    expect_snap(64'h0000_0000_0000_0800, 2);
    d0 = done_cnt;
    pulse_start();
    trig();
    wait_beats_left(64, 2000);
    tick(2);
    trig();
    wait_idle(2000);
    tick(1);
    chk("t3_done_cnt", 32'(done_cnt - d0), 1);
    chk("t3_beats_sent", beats_sent, 128);
    chk("t3_leftover", 32'(exp_beat.size() + exp_addr.size()), 0);
    dmode = 0;
    cmode = 0;
    tick(2);

    // Trigger dropped mid-stream is flagged and not counted
    cfg(64'h4000, 1, 2, 2);
    expect_snap(64'h4000, 1);
    expect_snap(64'h4800, 1);
    pulse_start();
    trig(); trig();
    wait_beats_left(56, 500);
    trig();
    chk("t4_drop_flag", err_trig_drop, 1);
    wait_beats_left(32, 500);
    tick(3);
    trig();
    tick(10);
    chk("t4_not_counted", 32'(exp_addr.size()), 1);
    chk("t4_no_beats", 32'(exp_beat.size()), 32);
    trig();
    wait_idle(1000);
    tick(1);
    chk("t4_leftover", 32'(exp_beat.size() + exp_addr.size()), 0);

    // Bad configuration
    cfg(64'h8000, 0, 1, 1);
    r0 = rd_cnt;
    pulse_start();
    chk("t5_err_cfg", err_cfg, 1);
    chk("t5_busy", busy, 0);
    trig();
    tick(10);
    chk("t5_busy_later", busy, 0);
    chk("t5_no_reads", 32'(rd_cnt - r0), 0);

    // Reset in the middle of a burst
    cfg(64'h1000, 2, 1, 1);
    expect_snap(64'h1000, 2);
    d0 = done_cnt;
    pulse_start();
    trig();
    wait_beats_left(50, 500);
    rst_n = 1'b0;
    tick(1);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_valid", bus.cmd_valid, 0);
    chk("t6_data_valid", bus.data_valid, 0);
    chk("t6_data_out", bus.data_out, 0);
    chk("t6_mem_rd_en", bus.mem_rd_en, 0);
    chk("t6_cmd_addr", bus.cmd_addr, 0);
    chk("t6_cmd_len", bus.cmd_len, 0);
    chk("t6_beats_sent", beats_sent, 0);
    chk("t6_errs", {err_cfg, err_trig_drop}, 0);
    rst_n = 1'b1;
    exp_beat.delete();
    exp_addr.delete();
    exp_len.delete();
    tick(20);
    chk("t6_no_done", 32'(done_cnt - d0), 0);
    expect_snap(64'h1000, 2);
    pulse_start();
    trig();
    wait_idle(1000);
    tick(1);
    chk("t6_rerun_done", 32'(done_cnt - d0), 1);
    chk("t6_rerun_beats", beats_sent, 64);
    chk("t6_leftover", 32'(exp_beat.size() + exp_addr.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
